// File: rtl/regf_wb_arbiter.sv
// rtl/regf_wb_arbiter.sv - round-robin regfile writeback arbiter with busy scoreboard; optional forwarding under WB_BYPASS_EN
module regf_wb_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*5-1:0] req_rd_s,
  input  logic [N_REQ*32-1:0] req_rd_v,
  output logic [N_REQ-1:0]   req_ready,
  input  logic               issue_valid,
  input  logic [4:0]         issue_rd_s,
  output logic               regf_we,
  output logic [4:0]         regf_rd_s,
  output logic [31:0]        regf_rd_v,
  output logic [31:0]        busy
`ifdef WB_BYPASS_EN
  ,
  input  logic [4:0]         rs1_s,
  input  logic [4:0]         rs2_s,
  output logic               rs1_fwd,
  output logic [31:0]        rs1_fwd_v,
  output logic               rs2_fwd,
  output logic [31:0]        rs2_fwd_v
`endif
);

  // Pointer width covers indices 0..N_REQ-1 for N_REQ in 2..4.
  localparam int PW = (N_REQ > 2) ? 2 : 1;

  logic [PW-1:0] rr_q, rr_d;
  logic [PW-1:0] grant_idx;
  logic [PW:0]   cand;
  logic [PW:0]   rr_inc;
  logic          found;
  logic [4:0]    sel_rd;
  logic [31:0]   sel_v;

  logic          regf_we_q, regf_we_d;
  logic [4:0]    regf_rd_s_q, regf_rd_s_d;
  logic [31:0]   regf_rd_v_q, regf_rd_v_d;
  logic [31:0]   busy_q, busy_d;

  // Round-robin search from rr_q; only req_valid and the pointer feed the grant.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(N_REQ)) begin
        cand = cand - (PW+1)'(N_REQ);
      end
      if (!found && req_valid[cand[PW-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[PW-1:0];
      end
    end
    req_ready = found ? (N_REQ'(1) << grant_idx) : '0;
  end

  // Winner's payload and the pointer/regfile/scoreboard next state.
  always_comb begin
    sel_rd      = req_rd_s[grant_idx*5 +: 5];
    sel_v       = req_rd_v[grant_idx*32 +: 32];
    rr_inc      = {1'b0, grant_idx} + (PW+1)'(1);
    rr_d        = rr_q;
    regf_we_d   = 1'b0;
    regf_rd_s_d = regf_rd_s_q;
    regf_rd_v_d = regf_rd_v_q;
    busy_d      = busy_q;
    if (found) begin
      rr_d        = (rr_inc == (PW+1)'(N_REQ)) ? '0 : rr_inc[PW-1:0];
      regf_we_d   = (sel_rd != 5'd0);
      regf_rd_s_d = sel_rd;
      regf_rd_v_d = sel_v;
      if (sel_rd != 5'd0) begin
        busy_d[sel_rd] = 1'b0;
      end
    end
    // A set after the clear lets a newly issued producer win over the retiring one.
    if (issue_valid && issue_rd_s != 5'd0) begin
      busy_d[issue_rd_s] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Pointer, registered write port and scoreboard state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q        <= '0;
      regf_we_q   <= 1'b0;
      regf_rd_s_q <= 5'd0;
      regf_rd_v_q <= 32'd0;
      busy_q      <= 32'd0;
    end else begin
      rr_q        <= rr_d;
      regf_we_q   <= regf_we_d;
      regf_rd_s_q <= regf_rd_s_d;
      regf_rd_v_q <= regf_rd_v_d;
      busy_q      <= busy_d;
    end
  end

  assign regf_we   = regf_we_q;
  assign regf_rd_s = regf_rd_s_q;
  assign regf_rd_v = regf_rd_v_q;
  assign busy      = busy_q;

`ifdef WB_BYPASS_EN
  logic        rs1_fwd_q, rs2_fwd_q;
  logic [31:0] rs1_fwd_v_q, rs2_fwd_v_q;
  logic        rs1_hit, rs2_hit;

  // A read that sampled the regfile while this write was committing saw stale data.
  always_comb begin
    rs1_hit = regf_we_q && (regf_rd_s_q == rs1_s) && (rs1_s != 5'd0);
    rs2_hit = regf_we_q && (regf_rd_s_q == rs2_s) && (rs2_s != 5'd0);
  end

  // Register the forward flag and capture the committing value on a hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rs1_fwd_q   <= 1'b0;
      rs2_fwd_q   <= 1'b0;
      rs1_fwd_v_q <= 32'd0;
      rs2_fwd_v_q <= 32'd0;
    end else begin
      rs1_fwd_q <= rs1_hit;
      rs2_fwd_q <= rs2_hit;
      if (rs1_hit) rs1_fwd_v_q <= regf_rd_v_q;
      if (rs2_hit) rs2_fwd_v_q <= regf_rd_v_q;
    end
  end

  assign rs1_fwd   = rs1_fwd_q;
  assign rs2_fwd   = rs2_fwd_q;
  assign rs1_fwd_v = rs1_fwd_v_q;
  assign rs2_fwd_v = rs2_fwd_v_q;
`endif

endmodule

// File: tb/tb_regf_wb_arbiter.sv
// tb/tb_regf_wb_arbiter.sv - directed scoreboard bench for regf_wb_arbiter
module tb_regf_wb_arbiter;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*5-1:0] req_rd_s;
  logic [N*32-1:0] req_rd_v;
  logic [N-1:0]   req_ready;
  logic           issue_valid;
  logic [4:0]     issue_rd_s;
  logic           regf_we;
  logic [4:0]     regf_rd_s;
  logic [31:0]    regf_rd_v;
  logic [31:0]    busy;
`ifdef WB_BYPASS_EN
  logic [4:0]     rs1_s, rs2_s;
  logic           rs1_fwd, rs2_fwd;
  logic [31:0]    rs1_fwd_v, rs2_fwd_v;
  logic           e_f1, e_f2;
  logic [31:0]    e_f1v, e_f2v;
`endif

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] v;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         cur;
  int          m_rr;
  logic [31:0] m_busy;
  int          tests = 0;
  int          fails = 0;

  regf_wb_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rd_s(req_rd_s), .req_rd_v(req_rd_v), .req_ready(req_ready),
    .issue_valid(issue_valid), .issue_rd_s(issue_rd_s),
    .regf_we(regf_we), .regf_rd_s(regf_rd_s), .regf_rd_v(regf_rd_v), .busy(busy)
`ifdef WB_BYPASS_EN
    , .rs1_s(rs1_s), .rs2_s(rs2_s), .rs1_fwd(rs1_fwd), .rs1_fwd_v(rs1_fwd_v),
    .rs2_fwd(rs2_fwd), .rs2_fwd_v(rs2_fwd_v)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_we"}, regf_we, cur.we);
    chk({tag, "_rd_s"}, regf_rd_s, cur.rd);
    chk({tag, "_rd_v"}, regf_rd_v, cur.v);
    chk({tag, "_busy"}, busy, m_busy);
`ifdef WB_BYPASS_EN
    chk({tag, "_rs1_fwd"}, rs1_fwd, e_f1);
    chk({tag, "_rs1_fwd_v"}, rs1_fwd_v, e_f1v);
    chk({tag, "_rs2_fwd"}, rs2_fwd, e_f2);
    chk({tag, "_rs2_fwd_v"}, rs2_fwd_v, e_f2v);
`endif
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    req_valid = '0;
    issue_valid = 1'b0;
    issue_rd_s = 5'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_rr = 0;
    m_busy = 32'd0;
    cur = '0;
    exp_q.delete();
`ifdef WB_BYPASS_EN
    e_f1 = 1'b0; e_f2 = 1'b0; e_f1v = 32'd0; e_f2v = 32'd0;
`endif
    check_outputs(tag);
    chk({tag, "_ready"}, req_ready, 0);
  endtask

  task automatic step(input logic [N-1:0] v, input logic [N*5-1:0] rd, input logic [N*32-1:0] d,
                      input logic iv, input logic [4:0] ird, input string tag);
    int  g;
    wr_t e;
    req_valid = v; req_rd_s = rd; req_rd_v = d;
    issue_valid = iv; issue_rd_s = ird;
    @(negedge clk);
    g = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_rr + k) % N;
      if (g < 0 && v[idx]) g = idx;
    end
    chk({tag, "_ready"}, req_ready, (g < 0) ? 0 : (1 << g));
    e.we = 1'b0; e.rd = cur.rd; e.v = cur.v;
    if (g >= 0) begin
      e.rd = rd[g*5 +: 5];
      e.v  = d[g*32 +: 32];
      e.we = (e.rd != 5'd0);
      if (e.rd != 5'd0) m_busy[e.rd] = 1'b0;
      m_rr = (g + 1) % N;
    end
    if (iv && ird != 5'd0) m_busy[ird] = 1'b1;
`ifdef WB_BYPASS_EN
    e_f1 = cur.we && (cur.rd == rs1_s) && (rs1_s != 5'd0);
    e_f2 = cur.we && (cur.rd == rs2_s) && (rs2_s != 5'd0);
    if (e_f1) e_f1v = cur.v;
    if (e_f2) e_f2v = cur.v;
`endif
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cur = exp_q.pop_front();
    check_outputs(tag);
  endtask

  initial begin
    req_rd_s = '0; req_rd_v = '0;
`ifdef WB_BYPASS_EN
    rs1_s = 5'd0; rs2_s = 5'd0;
`endif
    do_reset("reset");

    step(2'b01, {5'd0, 5'd5}, {32'd0, 32'hDEADBEEF}, 1'b0, 5'd0, "first");
    chk("first_const_v", regf_rd_v, 64'hDEADBEEF);

    do_reset("reset2");
    for (int i = 0; i < 4; i++) begin
      step(2'b11, {5'd2, 5'd1}, {32'h2222, 32'h1111}, 1'b0, 5'd0, "contend");
      chk("contend_const_rd", regf_rd_s, (i % 2 == 0) ? 1 : 2);
    end
    step(2'b00, {5'd0, 5'd0}, {32'd0, 32'd0}, 1'b0, 5'd0, "idle");

    step(2'b10, {5'd0, 5'd0}, {32'h1234, 32'd0}, 1'b0, 5'd0, "x0");
    chk("x0_bit0", busy[0], 0);

    step(2'b00, {5'd0, 5'd0}, {32'd0, 32'd0}, 1'b1, 5'd7, "sb_set");
    step(2'b01, {5'd0, 5'd7}, {32'd0, 32'h77}, 1'b1, 5'd7, "sb_setwin");
    chk("sb_setwin_const", busy[7], 1);
    step(2'b01, {5'd0, 5'd7}, {32'd0, 32'h78}, 1'b0, 5'd0, "sb_clr");
    chk("sb_clr_const", busy[7], 0);
    step(2'b01, {5'd0, 5'd7}, {32'd0, 32'h79}, 1'b0, 5'd0, "sb_clr_idle");

    step(2'b00, {5'd0, 5'd0}, {32'd0, 32'd0}, 1'b1, 5'd9, "mid_issue");
    step(2'b01, {5'd0, 5'd9}, {32'd0, 32'h99}, 1'b1, 5'd9, "mid_xfer");
    do_reset("mid_rst");
    step(2'b11, {5'd12, 5'd11}, {32'hBB, 32'hAA}, 1'b0, 5'd0, "post_rst");
    chk("post_rst_const_rd", regf_rd_s, 11);

`ifdef WB_BYPASS_EN
    step(2'b01, {5'd0, 5'd3}, {32'd0, 32'hA5A5A5A5}, 1'b0, 5'd0, "byp_wr");
    rs1_s = 5'd3; rs2_s = 5'd4;
    step(2'b00, {5'd0, 5'd0}, {32'd0, 32'd0}, 1'b0, 5'd0, "byp_fwd");
    chk("byp_const_fwd1", rs1_fwd, 1);
    chk("byp_const_fwd1v", rs1_fwd_v, 64'hA5A5A5A5);
    chk("byp_const_fwd2", rs2_fwd, 0);
    step(2'b00, {5'd0, 5'd0}, {32'd0, 32'd0}, 1'b0, 5'd0, "byp_hold");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
